serv_dbus_ctrl: RTL and testbench
=================================

Name: serv_dbus_ctrl

Overview:
Data-bus transaction controller between the core's load/store path and the external Wishbone data bus.
- Accepts one request per memory instruction, carrying the address, the shifted write word and the byte-lane select from the memory interface.
- Runs a single Wishbone classic cycle and captures read data.
- Reports completion, bus error, misalignment trap or timeout back to the core state machine.

Parameters:
TIMEOUT_W, 8, width of the ack-wait counter; a cycle aborts after 2^TIMEOUT_W-1 cycles without a response.
WITH_TIMEOUT, 1, 0 disables the timeout: the controller waits indefinitely for ack/err.

Ports:
i_clk  in  1  clock, all state on the rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  start request, sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_adr  in  32  byte address
i_dat  in  32  write data, already lane-shifted
i_sel  in  4  byte-lane select from the memory interface
i_misalign  in  1  access is misaligned; no bus cycle is issued
o_busy  out  1  high in any state other than IDLE
o_ack  out  1  one-cycle pulse: transaction completed OK
o_err  out  1  one-cycle pulse: bus error, timeout or misalign
o_rdt  out  32  last captured load data
o_wb_adr  out  32  word address {adr[31:2],2'b00}
o_wb_dat  out  32  registered write data
o_wb_sel  out  4  registered byte select
o_wb_we  out  1  registered write enable
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe, equal to cyc
i_wb_rdt  in  32  read data
i_wb_ack  in  1  slave acknowledge
i_wb_err  in  1  slave error

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - cyc, stb, o_ack, o_err and o_busy are 0.
  - o_rdt, o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we are 0.
  - Timeout counter is 0.
  - Asserting reset mid-cycle drops cyc/stb immediately, with no ack/err pulse.
- States: IDLE, BUS, RESP.
- IDLE, i_req=1 and i_misalign=0:
  - Register adr (low 2 bits forced 0), dat, sel and we.
  - Clear the counter and go to BUS.
  - cyc/stb rise on the next edge, so cyc is visible in the cycle after req.
- IDLE, i_req=1 and i_misalign=1:
  - Go to RESP with the error flag set.
  - No Wishbone activity at all.
- BUS: cyc=stb=1. Address, data, sel and we stay stable for the whole cycle.
  - i_wb_err=1: go to RESP with error. err wins over a simultaneous ack.
  - i_wb_ack=1 and no err: go to RESP with OK. If !we, capture i_wb_rdt into o_rdt.
  - Neither ack nor err: the counter increments.
    - When WITH_TIMEOUT=1 and the counter is all-ones, go to RESP with error.
    - An ack arriving on that terminal cycle wins over the timeout.
  - cyc/stb deassert on the edge leaving BUS, so they are high for exactly N cycles.
- RESP:
  - o_ack or o_err is high for exactly one cycle, then the state returns to IDLE.
  - o_busy is 1 here.
- Timing:
  - Latency: req at cycle 0, ack at cycle k (k≥1) gives the o_ack pulse at cycle k+1.
  - The earliest next request is accepted at cycle k+2.
- i_req while busy (BUS/RESP) is ignored, not queued.
- Stores never modify o_rdt. Errored loads leave o_rdt unchanged.
- o_rdt holds its value until the next successful load.
- The counter saturates and never wraps.

Test Plan:
- Load: req, we=0, adr=0x0000_1006, sel=4'b1100; slave acks 3 cycles after cyc rises with rdt=0xDEAD_BEEF.
  - Required: o_wb_adr=0x0000_1004 and sel=1100.
  - cyc high 3 cycles, then o_ack pulse 1 cycle, o_rdt=0xDEADBEEF, o_err never high.
- Store: req, we=1, dat=0x1122_3344, sel=1111; slave acks the first cycle.
  - Required: cyc high 1 cycle, o_wb_dat=0x11223344, o_ack pulse, o_rdt unchanged.
- Misalign: req with i_misalign=1 → cyc never rises, o_err pulse the cycle after req, o_busy high exactly 1 cycle.
- Timeout with TIMEOUT_W=3: no ack → cyc high 7 cycles, then o_err pulse. Repeat with ack on the 7th cycle → o_ack instead.
- Simultaneous ack+err → o_err only, o_rdt unchanged. A second i_req pulsed during BUS → ignored, only one cycle observed.
- Reset mid-BUS: drop i_rst_n while cyc=1 → cyc/stb go to 0 without a clock edge, no ack/err pulse. After release, a new req is accepted.

Source files
------------

// File: rtl/serv_dbus_ctrl.sv
// Data-bus controller: turns one load/store request into a single Wishbone
// classic cycle and reports completion, bus error, misalignment or timeout.
module serv_dbus_ctrl #(
    parameter int TIMEOUT_W    = 8,
    parameter int WITH_TIMEOUT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic [3:0]  i_sel,
    input  logic        i_misalign,
    output logic        o_busy,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdt,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_e                 state_q;
    logic [TIMEOUT_W-1:0]   cnt_q;
    logic [TIMEOUT_W-1:0]   cnt_d;
    logic                   tmo;
    logic                   busy_q, ack_q, err_q, cyc_q, we_q;
    logic [31:0]            rdt_q, adr_q, dat_q;
    logic [3:0]             sel_q;

    // Saturating wait counter; the abort fires on the cycle the count would
    // reach all-ones, so cyc stays up for exactly 2^TIMEOUT_W-1 cycles.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign tmo   = (WITH_TIMEOUT != 0) && (cnt_d == CNT_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            rdt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req) begin
                        busy_q <= 1'b1;
                        if (i_misalign) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= BUS;
                            cyc_q   <= 1'b1;
                            cnt_q   <= '0;
                            adr_q   <= i_adr & 32'hFFFF_FFFC;
                            dat_q   <= i_dat;
                            sel_q   <= i_sel;
                            we_q    <= i_we;
                        end
                    end
                end
                BUS: begin
                    // err beats ack, ack beats a same-cycle timeout
                    if (i_wb_err) begin
                        state_q <= RESP;
                        cyc_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (i_wb_ack) begin
                        state_q <= RESP;
                        cyc_q   <= 1'b0;
                        ack_q   <= 1'b1;
                        if (!we_q) rdt_q <= i_wb_rdt;
                    end else begin
                        cnt_q <= cnt_d;
                        if (tmo) begin
                            state_q <= RESP;
                            cyc_q   <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_ack    = ack_q;
    assign o_err    = err_q;
    assign o_rdt    = rdt_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;
    assign o_wb_stb = cyc_q;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Bench for serv_dbus_ctrl: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_serv_dbus_ctrl;
    localparam int TW   = 3;
    localparam int TMAX = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        d_req = 1'b0, d_we = 1'b0, d_mis = 1'b0;
    logic [31:0] d_adr = '0, d_dat = '0, d_rdt = '0;
    logic [3:0]  d_sel = '0;
    logic        d_ack = 1'b0, d_err = 1'b0;

    logic        o_busy, o_ack, o_err, o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] o_rdt, o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;

    always #5 clk = ~clk;

    serv_dbus_ctrl #(.TIMEOUT_W(TW), .WITH_TIMEOUT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req(d_req), .i_we(d_we), .i_adr(d_adr), .i_dat(d_dat),
        .i_sel(d_sel), .i_misalign(d_mis),
        .o_busy(o_busy), .o_ack(o_ack), .o_err(o_err), .o_rdt(o_rdt),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_rdt(d_rdt), .i_wb_ack(d_ack), .i_wb_err(d_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Model: phase 0 = no transaction, 1 = waiting on the slave, 2 = reporting.
    int          m_ph, m_wait;
    bit          m_ok, m_we;
    logic [31:0] m_adr, m_dat, m_rdt;
    logic [3:0]  m_sel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= 0; m_wait <= 0; m_ok <= 1'b0; m_we <= 1'b0;
            m_adr <= '0; m_dat <= '0; m_rdt <= '0; m_sel <= '0;
        end else begin
            case (m_ph)
                0: if (d_req) begin
                    if (d_mis) begin
                        m_ph <= 2; m_ok <= 1'b0;
                    end else begin
                        m_ph <= 1; m_wait <= 0;
                        m_adr <= d_adr & ~32'h3; m_dat <= d_dat;
                        m_sel <= d_sel; m_we <= d_we;
                    end
                end
                1: if (d_err) begin
                    m_ph <= 2; m_ok <= 1'b0;
                end else if (d_ack) begin
                    m_ph <= 2; m_ok <= 1'b1;
                    if (!m_we) m_rdt <= d_rdt;
                end else begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 == TMAX) begin
                        m_ph <= 2; m_ok <= 1'b0;
                    end
                end
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busy", 32'(o_busy), 32'(m_ph != 0));
            chk("cyc",  32'(o_wb_cyc), 32'(m_ph == 1));
            chk("stb",  32'(o_wb_stb), 32'(m_ph == 1));
            chk("ack",  32'(o_ack), 32'(m_ph == 2 && m_ok));
            chk("err",  32'(o_err), 32'(m_ph == 2 && !m_ok));
            chk("rdt",  o_rdt, m_rdt);
            chk("wb_adr", o_wb_adr, m_adr);
            chk("wb_dat", o_wb_dat, m_dat);
            chk("wb_sel", 32'(o_wb_sel), 32'(m_sel));
            chk("wb_we",  32'(o_wb_we), 32'(m_we));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Called with a request set up for cycle 0; observes cycles 1..20.
    task automatic run_txn(input int ack_at, input bit both, input logic [31:0] rdt,
                           input bit req_in_bus,
                           output int ncyc, output int nack, output int nerr,
                           output int nbusy, output int resp_at,
                           output logic [31:0] adr1, output logic [31:0] dat1,
                           output logic [3:0] sel1);
        ncyc = 0; nack = 0; nerr = 0; nbusy = 0; resp_at = -1;
        adr1 = '0; dat1 = '0; sel1 = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ncyc  += int'(o_wb_cyc);
            nack  += int'(o_ack);
            nerr  += int'(o_err);
            nbusy += int'(o_busy);
            if ((o_ack || o_err) && resp_at < 0) resp_at = c;
            if (c == 1) begin
                adr1 = o_wb_adr; dat1 = o_wb_dat; sel1 = o_wb_sel;
            end
            d_req = req_in_bus && (c == 2);
            d_mis = 1'b0;
            d_ack = (c == ack_at);
            d_err = both && (c == ack_at);
            d_rdt = rdt;
        end
        d_ack = 1'b0; d_err = 1'b0;
    endtask

    task automatic setreq(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit mis);
        d_req = 1'b1; d_we = we; d_adr = adr; d_dat = dat; d_sel = sel; d_mis = mis;
    endtask

    initial begin
        int nc, na, ne, nb, ra;
        logic [31:0] a1, dt1;
        logic [3:0]  s1;

        #1;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_cyc",  32'(o_wb_cyc), 0);
        chk("rst_stb",  32'(o_wb_stb), 0);
        chk("rst_ack",  32'(o_ack), 0);
        chk("rst_err",  32'(o_err), 0);
        chk("rst_rdt",  o_rdt, 0);
        chk("rst_adr",  o_wb_adr, 0);
        chk("rst_dat",  o_wb_dat, 0);
        chk("rst_sel",  32'(o_wb_sel), 0);
        chk("rst_we",   32'(o_wb_we), 0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        setreq(1'b0, 32'h0000_1006, 32'hAAAA_5555, 4'b1100, 1'b0);
        run_txn(3, 1'b0, 32'hDEAD_BEEF, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("load_adr", a1, 32'h0000_1004);
        chk("load_sel", 32'(s1), 32'hC);
        chk("load_ncyc", nc, 3);
        chk("load_nack", na, 1);
        chk("load_ackat", ra, 4);
        chk("load_nerr", ne, 0);
        chk("load_rdt", o_rdt, 32'hDEAD_BEEF);

        setreq(1'b1, 32'h0000_2000, 32'h1122_3344, 4'b1111, 1'b0);
        run_txn(1, 1'b0, 32'h5555_AAAA, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("st_ncyc", nc, 1);
        chk("st_dat", dt1, 32'h1122_3344);
        chk("st_nack", na, 1);
        chk("st_ackat", ra, 2);
        chk("st_rdt", o_rdt, 32'hDEAD_BEEF);

        setreq(1'b0, 32'h0000_3001, 32'h0, 4'b0001, 1'b1);
        run_txn(0, 1'b0, 32'h0, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("mis_ncyc", nc, 0);
        chk("mis_nerr", ne, 1);
        chk("mis_errat", ra, 1);
        chk("mis_nbusy", nb, 1);
        chk("mis_nack", na, 0);

        setreq(1'b0, 32'h0000_4000, 32'h0, 4'b1111, 1'b0);
        run_txn(0, 1'b0, 32'h0, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("tmo_ncyc", nc, 7);
        chk("tmo_nerr", ne, 1);
        chk("tmo_errat", ra, 8);
        chk("tmo_nack", na, 0);

        setreq(1'b0, 32'h0000_4004, 32'h0, 4'b1111, 1'b0);
        run_txn(7, 1'b0, 32'hCAFE_F00D, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("ack7_ncyc", nc, 7);
        chk("ack7_nack", na, 1);
        chk("ack7_nerr", ne, 0);
        chk("ack7_ackat", ra, 8);
        chk("ack7_rdt", o_rdt, 32'hCAFE_F00D);

        setreq(1'b0, 32'h0000_5000, 32'h0, 4'b0011, 1'b0);
        run_txn(2, 1'b1, 32'h1234_5678, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("both_nerr", ne, 1);
        chk("both_nack", na, 0);
        chk("both_rdt", o_rdt, 32'hCAFE_F00D);

        setreq(1'b1, 32'h0000_6000, 32'h0BAD_0BAD, 4'b1111, 1'b0);
        run_txn(4, 1'b0, 32'h0, 1'b1, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("busyreq_ncyc", nc, 4);
        chk("busyreq_nack", na, 1);
        chk("busyreq_nbusy", nb, 5);

        setreq(1'b0, 32'h0000_7000, 32'h0, 4'b1111, 1'b0);
        tick();
        d_req = 1'b0;
        tick();
        chk("mid_cyc_pre", 32'(o_wb_cyc), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_cyc", 32'(o_wb_cyc), 0);
        chk("mid_stb", 32'(o_wb_stb), 0);
        chk("mid_busy", 32'(o_busy), 0);
        tick();
        chk("mid_ack", 32'(o_ack), 0);
        chk("mid_err", 32'(o_err), 0);
        rst_n = 1'b1;
        tick();
        setreq(1'b0, 32'h0000_8008, 32'h0, 4'b1111, 1'b0);
        run_txn(1, 1'b0, 32'h7777_8888, 1'b0, nc, na, ne, nb, ra, a1, dt1, s1);
        chk("post_nack", na, 1);
        chk("post_rdt", o_rdt, 32'h7777_8888);

        for (int i = 0; i < 3000; i++) begin
            tick();
            d_req = ($urandom % 2) == 0;
            d_mis = ($urandom % 6) == 0;
            d_we  = ($urandom % 2) == 0;
            d_adr = $urandom;
            d_dat = $urandom;
            d_sel = 4'($urandom);
            d_rdt = $urandom;
            d_ack = (m_ph == 1) ? (($urandom % 4) == 0) : (($urandom % 16) == 0);
            d_err = ($urandom % 16) == 0;
        end
        tick();
        d_req = 1'b0; d_ack = 1'b0; d_err = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
